// File: rtl/d_branch_ctrl_pkg.sv
// d_branch_ctrl_pkg: shared branch-op, forward-select and FSM types plus the per-source hazard depth helper
package d_branch_ctrl_pkg;
    typedef enum logic [2:0] {
        BOP_NONE = 3'b000,
        BOP_BEQ  = 3'b001,
        BOP_BNE  = 3'b010,
        BOP_BLEZ = 3'b011,
        BOP_BGTZ = 3'b100,
        BOP_BLTZ = 3'b101,
        BOP_BGEZ = 3'b110
    } bop_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Stall cycles needed before src can be compared in decode:
    // load in EX -> 2, ALU in EX or load in MEM -> 1, otherwise 0.
    function automatic logic [1:0] hazard_depth(
        input logic       used,
        input logic [4:0] src,
        input logic       ex_wr,
        input logic [4:0] ex_rd,
        input logic       ex_memrd,
        input logic       mem_wr,
        input logic [4:0] mem_rd,
        input logic       mem_memrd
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = used && (src != 5'd0) && ex_wr && (ex_rd == src);
        mem_hit = used && (src != 5'd0) && mem_wr && (mem_rd == src);
        return ex_hit ? (ex_memrd ? 2'd2 : 2'd1) : (mem_hit && mem_memrd) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/d_fwd_sel.sv
// d_fwd_sel: picks the compare-operand source for one register index
//   src/used            : register index and whether the branch reads it
//   mem_wr/mem_rd/mem_memrd : MEM-stage writer (loads cannot forward from MEM)
//   wb_wr/wb_rd         : WB-stage writer
//   sel                 : FWD_RF, FWD_MEM (priority) or FWD_WB
module d_fwd_sel
    import d_branch_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       used,
    input  logic       mem_wr,
    input  logic [4:0] mem_rd,
    input  logic       mem_memrd,
    input  logic       wb_wr,
    input  logic [4:0] wb_rd,
    output fwd_sel_e   sel
);
    always_comb begin
        sel = (!used || src == 5'd0)                            ? FWD_RF  :
              (mem_wr && !mem_memrd && mem_rd == src)           ? FWD_MEM :
              (wb_wr && wb_rd == src)                           ? FWD_WB  : FWD_RF;
    end
endmodule

// File: rtl/d_branch_ctrl.sv
// d_branch_ctrl: decode-stage branch sequencer (hazard stall, operand forwarding, PC redirect, statistics)
//   i_clk, i_rst (async, active high), i_stall_ext (global freeze)
//   i_con_bop, i_rs_addr, i_rt_addr : branch op and compare sources from decode
//   i_ex_* / i_mem_* / i_wb_*       : downstream writers for hazard and forwarding decisions
//   i_con_ifbranch                  : comparator result for o_con_bop this cycle
//   o_con_bop, o_fwd_rs, o_fwd_rt   : comparator op and operand selects
//   o_stall, o_pc_redirect, o_flush_if : pipeline control
//   o_br_cnt, o_taken_cnt           : saturating branch statistics
module d_branch_ctrl
    import d_branch_ctrl_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_ext,
    input  logic [2:0]       i_con_bop,
    input  logic [4:0]       i_rs_addr,
    input  logic [4:0]       i_rt_addr,
    input  logic             i_ex_wr,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memrd,
    input  logic             i_mem_wr,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_memrd,
    input  logic             i_wb_wr,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_con_ifbranch,
    output logic [2:0]       o_con_bop,
    output logic [1:0]       o_fwd_rs,
    output logic [1:0]       o_fwd_rt,
    output logic             o_stall,
    output logic             o_pc_redirect,
    output logic             o_flush_if,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);
    state_e     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic [1:0] need_rs, need_rt, need;
    logic       is_br, rt_used, resolve;
    fwd_sel_e   fwd_rs, fwd_rt;

    assign is_br   = (i_con_bop != BOP_NONE) && (i_con_bop != 3'b111);
    assign rt_used = (i_con_bop == BOP_BEQ) || (i_con_bop == BOP_BNE);
    assign need_rs = hazard_depth(is_br, i_rs_addr, i_ex_wr, i_ex_rd, i_ex_memrd,
                                  i_mem_wr, i_mem_rd, i_mem_memrd);
    assign need_rt = hazard_depth(rt_used, i_rt_addr, i_ex_wr, i_ex_rd, i_ex_memrd,
                                  i_mem_wr, i_mem_rd, i_mem_memrd);
    assign need    = (need_rs > need_rt) ? need_rs : need_rt;
    assign resolve = !i_stall_ext && state == ST_IDLE && is_br && need == 2'd0;

    d_fwd_sel u_fwd_rs (
        .src(i_rs_addr), .used(resolve), .mem_wr(i_mem_wr), .mem_rd(i_mem_rd),
        .mem_memrd(i_mem_memrd), .wb_wr(i_wb_wr), .wb_rd(i_wb_rd), .sel(fwd_rs)
    );

    d_fwd_sel u_fwd_rt (
        .src(i_rt_addr), .used(resolve && rt_used), .mem_wr(i_mem_wr), .mem_rd(i_mem_rd),
        .mem_memrd(i_mem_memrd), .wb_wr(i_wb_wr), .wb_rd(i_wb_rd), .sel(fwd_rt)
    );

    assign o_fwd_rs = fwd_rs;
    assign o_fwd_rt = fwd_rt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            o_br_cnt    <= '0;
            o_taken_cnt <= '0;
        end else if (!i_stall_ext) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (resolve && !(&o_br_cnt))
                o_br_cnt <= o_br_cnt + CNT_W'(1);
            if (resolve && i_con_ifbranch && !(&o_taken_cnt))
                o_taken_cnt <= o_taken_cnt + CNT_W'(1);
        end
    end

    // The detecting IDLE cycle is the first stall; cnt holds the further
    // stall cycles spent in WAIT, so a branch stalls exactly N cycles in total.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        o_stall       = 1'b0;
        o_con_bop     = BOP_NONE;
        o_pc_redirect = 1'b0;
        o_flush_if    = 1'b0;
        if (i_stall_ext) begin
            o_stall = 1'b1;
        end else if (state == ST_WAIT) begin
            o_stall  = 1'b1;
            cnt_nx   = cnt - 2'd1;
            state_nx = (cnt <= 2'd1) ? ST_IDLE : ST_WAIT;
        end else if (is_br && need != 2'd0) begin
            o_stall  = 1'b1;
            cnt_nx   = need - 2'd1;
            state_nx = (need > 2'd1) ? ST_WAIT : ST_IDLE;
        end else if (is_br) begin
            o_con_bop     = i_con_bop;
            o_pc_redirect = i_con_ifbranch;
            o_flush_if    = i_con_ifbranch && (DELAY_SLOT == 0);
        end
    end
endmodule

// File: tb/tb_d_branch_ctrl.sv
// tb_d_branch_ctrl: directed checks of d_branch_ctrl (default build and DELAY_SLOT=0/CNT_W=2 build)
module tb_d_branch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall_ext = 1'b0;
    logic [2:0] bop = 3'd0;
    logic [4:0] rs = 5'd0, rt = 5'd0;
    logic       ex_wr = 1'b0, ex_memrd = 1'b0, mem_wr = 1'b0, mem_memrd = 1'b0, wb_wr = 1'b0;
    logic [4:0] ex_rd = 5'd0, mem_rd = 5'd0, wb_rd = 5'd0;
    logic       ifb = 1'b0;

    logic [2:0]  a_bop, b_bop;
    logic [1:0]  a_frs, a_frt, b_frs, b_frt;
    logic        a_stall, a_redir, a_flush, b_stall, b_redir, b_flush;
    logic [15:0] a_br, a_tk;
    logic [1:0]  b_br, b_tk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_branch_ctrl u_a (
        .i_clk(clk), .i_rst(rst), .i_stall_ext(stall_ext), .i_con_bop(bop),
        .i_rs_addr(rs), .i_rt_addr(rt), .i_ex_wr(ex_wr), .i_ex_rd(ex_rd), .i_ex_memrd(ex_memrd),
        .i_mem_wr(mem_wr), .i_mem_rd(mem_rd), .i_mem_memrd(mem_memrd), .i_wb_wr(wb_wr), .i_wb_rd(wb_rd),
        .i_con_ifbranch(ifb), .o_con_bop(a_bop), .o_fwd_rs(a_frs), .o_fwd_rt(a_frt),
        .o_stall(a_stall), .o_pc_redirect(a_redir), .o_flush_if(a_flush),
        .o_br_cnt(a_br), .o_taken_cnt(a_tk)
    );

    d_branch_ctrl #(.DELAY_SLOT(0), .CNT_W(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_stall_ext(stall_ext), .i_con_bop(bop),
        .i_rs_addr(rs), .i_rt_addr(rt), .i_ex_wr(ex_wr), .i_ex_rd(ex_rd), .i_ex_memrd(ex_memrd),
        .i_mem_wr(mem_wr), .i_mem_rd(mem_rd), .i_mem_memrd(mem_memrd), .i_wb_wr(wb_wr), .i_wb_rd(wb_rd),
        .i_con_ifbranch(ifb), .o_con_bop(b_bop), .o_fwd_rs(b_frs), .o_fwd_rt(b_frt),
        .o_stall(b_stall), .o_pc_redirect(b_redir), .o_flush_if(b_flush),
        .o_br_cnt(b_br), .o_taken_cnt(b_tk)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] b, input logic [4:0] s, input logic [4:0] t,
                         input logic exw, input logic [4:0] exd, input logic exl,
                         input logic mw, input logic [4:0] md, input logic ml,
                         input logic ww, input logic [4:0] wd, input logic taken);
        bop = b; rs = s; rt = t;
        ex_wr = exw; ex_rd = exd; ex_memrd = exl;
        mem_wr = mw; mem_rd = md; mem_memrd = ml;
        wb_wr = ww; wb_rd = wd; ifb = taken;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input int st, input int bp, input int rd);
        chk({tag, "_stall"}, int'(a_stall), st);
        chk({tag, "_bop"}, int'(a_bop), bp);
        chk({tag, "_redir"}, int'(a_redir), rd);
    endtask

    initial begin
        #2;
        chk("rst_stall", int'(a_stall), 0);
        chk("rst_bop", int'(a_bop), 0);
        chk("rst_br", int'(a_br), 0);
        chk("rst_tk", int'(a_tk), 0);
        chk("rst_b_br", int'(b_br), 0);
        tick;
        rst = 1'b0;

        // beq r3,r4 with no producers resolves at once
        drive(3'b001, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("beq", 0, 1, 1);
        chk("beq_a_flush", int'(a_flush), 0);
        chk("beq_b_flush", int'(b_flush), 1);
        chk("beq_frs", int'(a_frs), 0);
        tick;
        chk("beq_br", int'(a_br), 1);
        chk("beq_tk", int'(a_tk), 1);

        // bne r5 with a load to r5 in EX: two stall cycles, then WB forward
        drive(3'b010, 5'd5, 5'd6, 1, 5'd5, 1, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("bne_s1", 1, 0, 0);
        tick;
        drive(3'b010, 5'd5, 5'd6, 0, 5'd0, 0, 1, 5'd5, 1, 0, 5'd0, 1);
        ctl("bne_s2", 1, 0, 0);
        tick;
        drive(3'b010, 5'd5, 5'd6, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd5, 0);
        ctl("bne_res", 0, 2, 0);
        chk("bne_frs", int'(a_frs), 2);
        chk("bne_frt", int'(a_frt), 0);
        tick;
        chk("bne_br", int'(a_br), 2);
        chk("bne_tk", int'(a_tk), 1);

        // bgtz r7 with ALU op to r7 in EX: one stall, then MEM forward; rt ignored
        drive(3'b100, 5'd7, 5'd7, 1, 5'd7, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("bgtz_s1", 1, 0, 0);
        tick;
        drive(3'b100, 5'd7, 5'd7, 0, 5'd0, 0, 1, 5'd7, 0, 0, 5'd0, 1);
        ctl("bgtz_res", 0, 4, 1);
        chk("bgtz_frs", int'(a_frs), 1);
        chk("bgtz_frt", int'(a_frt), 0);
        tick;
        chk("bgtz_br", int'(a_br), 3);
        chk("bgtz_tk", int'(a_tk), 2);
        chk("bgtz_b_br", int'(b_br), 3);

        // register 0 never hazards nor forwards
        drive(3'b001, 5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 1, 5'd0, 0);
        ctl("r0", 0, 1, 0);
        chk("r0_frs", int'(a_frs), 0);
        chk("r0_frt", int'(a_frt), 0);
        tick;

        // MEM beats WB when both write r9
        drive(3'b001, 5'd9, 5'd2, 0, 5'd0, 0, 1, 5'd9, 0, 1, 5'd9, 0);
        ctl("prio", 0, 1, 0);
        chk("prio_frs", int'(a_frs), 1);
        chk("prio_frt", int'(a_frt), 0);
        tick;
        chk("prio_br", int'(a_br), 5);
        chk("prio_b_br_sat", int'(b_br), 3);

        // taken bltz: flush only without delay slot
        drive(3'b101, 5'd1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("bltz", 0, 5, 1);
        chk("bltz_a_flush", int'(a_flush), 0);
        chk("bltz_b_flush", int'(b_flush), 1);
        tick;
        chk("bltz_tk", int'(a_tk), 3);
        chk("bltz_b_tk", int'(b_tk), 3);

        // external freeze on a resolvable branch: nothing counted
        stall_ext = 1'b1;
        drive(3'b001, 5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("ext_idle", 1, 0, 0);
        chk("ext_idle_flush", int'(b_flush), 0);
        tick;
        chk("ext_idle_br", int'(a_br), 6);
        stall_ext = 1'b0;

        // external freeze inside WAIT holds the remaining wait
        drive(3'b001, 5'd8, 5'd10, 1, 5'd10, 1, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("frz_s1", 1, 0, 0);
        tick;
        stall_ext = 1'b1;
        drive(3'b001, 5'd8, 5'd10, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("frz_ext", 1, 0, 0);
        tick;
        tick;
        stall_ext = 1'b0;
        #1;
        ctl("frz_wait", 1, 0, 0);
        tick;
        drive(3'b001, 5'd8, 5'd10, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd10, 1);
        ctl("frz_res", 0, 1, 1);
        chk("frz_frt", int'(a_frt), 2);
        tick;
        chk("frz_br", int'(a_br), 7);
        chk("frz_tk", int'(a_tk), 4);
        chk("frz_b_tk_sat", int'(b_tk), 3);

        // reset in WAIT returns to IDLE and clears counters
        drive(3'b001, 5'd11, 5'd0, 1, 5'd11, 1, 0, 5'd0, 0, 0, 5'd0, 0);
        ctl("rw_s1", 1, 0, 0);
        tick;
        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        ctl("rw_rst", 0, 0, 0);
        chk("rw_br", int'(a_br), 0);
        chk("rw_b_tk", int'(b_tk), 0);
        tick;
        rst = 1'b0;
        drive(3'b001, 5'd11, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        ctl("rw_new", 0, 1, 1);
        tick;
        chk("rw_new_br", int'(a_br), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
